store_queue_multi: RTL

STORE_QUEUE_MULTI -- requirements
Module: store_queue_multi

---
 rtl/store_queue_multi_if.sv | 59 +++++
 rtl/store_queue_multi.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/store_queue_multi_if.sv
// Store queue bus bundle: enqueue, commit/flush control, forwarding lookup,
// cache write channel and occupancy status.
interface store_queue_multi_if #(
   parameter int NUM_ENTRIES = 8,
   parameter int DATA_W      = 32,
   parameter int SQN_W       = 7
);
   localparam int BYTES = DATA_W / 8;
   localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

   logic              in_st_valid;
   logic              in_st_ready;
   logic [SQN_W-1:0]  in_st_sqn;
   logic [31:0]       in_st_addr;
   logic [DATA_W-1:0] in_st_data;
   logic [BYTES-1:0]  in_st_wmask;

   logic [SQN_W-1:0]  in_cur_sqn;

   logic              in_flush_valid;
   logic [SQN_W-1:0]  in_flush_sqn;

   logic              in_ld_valid;
   logic [31:0]       in_ld_addr;
   logic [SQN_W-1:0]  in_ld_sqn;

   logic              out_fwd_valid;
   logic [DATA_W-1:0] out_fwd_data;
   logic [BYTES-1:0]  out_fwd_mask;

   logic              out_st_valid;
   logic              out_st_ready;
   logic [31:0]       out_st_addr;
   logic [DATA_W-1:0] out_st_data;
   logic [BYTES-1:0]  out_st_wmask;

   logic              out_empty;
   logic [CNT_W-1:0]  out_count;

   // Queue side
   modport slave (
      input  in_st_valid, in_st_sqn, in_st_addr, in_st_data, in_st_wmask,
      input  in_cur_sqn, in_flush_valid, in_flush_sqn,
      input  in_ld_valid, in_ld_addr, in_ld_sqn, out_st_ready,
      output in_st_ready, out_fwd_valid, out_fwd_data, out_fwd_mask,
      output out_st_valid, out_st_addr, out_st_data, out_st_wmask,
      output out_empty, out_count
   );

   // Core / cache side
   modport master (
      output in_st_valid, in_st_sqn, in_st_addr, in_st_data, in_st_wmask,
      output in_cur_sqn, in_flush_valid, in_flush_sqn,
      output in_ld_valid, in_ld_addr, in_ld_sqn, out_st_ready,
      input  in_st_ready, out_fwd_valid, out_fwd_data, out_fwd_mask,
      input  out_st_valid, out_st_addr, out_st_data, out_st_wmask,
      input  out_empty, out_count
   );
endinterface

// File: rtl/store_queue_multi.sv
// Store queue: circular buffer of program-ordered stores with sticky commit,
// misprediction squash, same-word coalescing into a cache write register and
// youngest-wins store-to-load forwarding.
module store_queue_multi #(
   parameter int NUM_ENTRIES = 8,
   parameter int DATA_W      = 32,
   parameter int SQN_W       = 7,
   parameter int COALESCE    = 1
) (
   input logic               clk,
   input logic               rst,
   store_queue_multi_if.slave sq
);
   localparam int BYTES = DATA_W / 8;
   localparam int IDX_W = $clog2(NUM_ENTRIES);
   localparam int PTR_W = IDX_W + 1;
   localparam int OFF_W = $clog2(BYTES);

   // Wrap-safe ordering: a is older than b
   function automatic logic f_older(input logic [SQN_W-1:0] a, input logic [SQN_W-1:0] b);
      logic [SQN_W-1:0] d;
      d = a - b;
      return d[SQN_W-1];
   endfunction

   logic [NUM_ENTRIES-1:0] r_valid;
   logic [NUM_ENTRIES-1:0] r_cmt;
   logic [SQN_W-1:0]       r_sqn  [NUM_ENTRIES];
   logic [31:0]            r_addr [NUM_ENTRIES];
   logic [DATA_W-1:0]      r_data [NUM_ENTRIES];
   logic [BYTES-1:0]       r_mask [NUM_ENTRIES];

   logic [PTR_W-1:0]       r_head, r_tail, r_count;
   logic                   r_empty;

   logic                   r_out_valid;
   logic [31:0]            r_out_addr;
   logic [DATA_W-1:0]      r_out_data;
   logic [BYTES-1:0]       r_out_mask;

   logic                   r_fwd_valid;
   logic [DATA_W-1:0]      r_fwd_data;
   logic [BYTES-1:0]       r_fwd_mask;

   logic [IDX_W-1:0]       w_head_idx, w_head1_idx, w_wr_idx, w_fidx;
   logic                   w_full, w_enq, w_out_free, w_pop0, w_pop1, w_out_valid_nxt;
   logic [NUM_ENTRIES-1:0] w_flush_vec;
   logic [PTR_W-1:0]       w_n_flush, w_n_pop, w_tail_ret, w_head_nxt, w_tail_nxt, w_count_nxt;
   logic [DATA_W-1:0]      w_mrg_data, w_fwd_data;
   logic [BYTES-1:0]       w_mrg_mask, w_fwd_mask;

   assign w_head_idx  = r_head[IDX_W-1:0];
   assign w_head1_idx = w_head_idx + IDX_W'(1);
   assign w_full      = (r_head[IDX_W-1:0] == r_tail[IDX_W-1:0]) && (r_head[IDX_W] != r_tail[IDX_W]);
   assign w_enq       = sq.in_st_valid && !w_full &&
                        !(sq.in_flush_valid && f_older(sq.in_flush_sqn, sq.in_st_sqn));
   assign w_out_free  = !r_out_valid || sq.out_st_ready;
   assign w_pop0      = w_out_free && r_valid[w_head_idx] && r_cmt[w_head_idx];
   assign w_pop1      = (COALESCE != 0) && w_pop0 && r_valid[w_head1_idx] && r_cmt[w_head1_idx] &&
                        (r_addr[w_head_idx][31:OFF_W] == r_addr[w_head1_idx][31:OFF_W]);
   assign w_out_valid_nxt = w_out_free ? w_pop0 : r_out_valid;

   // Squashed entries always form the young suffix of the queue, so retracting
   // tail by their population count lands on the oldest squashed slot.
   assign w_n_pop     = PTR_W'(w_pop0) + PTR_W'(w_pop1);
   assign w_tail_ret  = r_tail - w_n_flush;
   assign w_wr_idx    = w_tail_ret[IDX_W-1:0];
   assign w_head_nxt  = r_head + w_n_pop;
   assign w_tail_nxt  = w_tail_ret + PTR_W'(w_enq);
   assign w_count_nxt = w_tail_nxt - w_head_nxt;

   // Identify uncommitted entries younger than the flush point
   always_comb begin
      w_flush_vec = '0;
      w_n_flush   = '0;
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
         w_flush_vec[i] = sq.in_flush_valid && r_valid[i] && !r_cmt[i] &&
                          f_older(sq.in_flush_sqn, r_sqn[i]);
         w_n_flush      = w_n_flush + PTR_W'(w_flush_vec[i]);
      end
   end

   // Merge head+1 over head, younger bytes winning
   always_comb begin
      w_mrg_data = r_data[w_head_idx];
      w_mrg_mask = r_mask[w_head_idx];
      if (w_pop1) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_mask[w_head1_idx][b]) w_mrg_data[b*8 +: 8] = r_data[w_head1_idx][b*8 +: 8];
         end
         w_mrg_mask = r_mask[w_head_idx] | r_mask[w_head1_idx];
      end
   end

   // Forwarding lookup: output register is oldest, then walk head to tail
   always_comb begin
      w_fwd_data = '0;
      w_fwd_mask = '0;
      w_fidx     = '0;
      if (r_out_valid && (r_out_addr[31:OFF_W] == sq.in_ld_addr[31:OFF_W])) begin
         for (int unsigned b = 0; b < BYTES; b++) begin
            if (r_out_mask[b]) begin
               w_fwd_mask[b]        = 1'b1;
               w_fwd_data[b*8 +: 8] = r_out_data[b*8 +: 8];
            end
         end
      end
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         w_fidx = w_head_idx + IDX_W'(k);
         if (r_valid[w_fidx] && (r_addr[w_fidx][31:OFF_W] == sq.in_ld_addr[31:OFF_W]) &&
             (r_cmt[w_fidx] || f_older(r_sqn[w_fidx], sq.in_ld_sqn))) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
               if (r_mask[w_fidx][b]) begin
                  w_fwd_mask[b]        = 1'b1;
                  w_fwd_data[b*8 +: 8] = r_data[w_fidx][b*8 +: 8];
               end
            end
         end
      end
   end

   // Entry valid/committed bookkeeping: commit, squash, pop, enqueue
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= '0;
         r_cmt   <= '0;
      end else begin
         for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
            if (r_valid[i] && f_older(r_sqn[i], sq.in_cur_sqn)) r_cmt[i] <= 1'b1;
            if (w_flush_vec[i]) begin
               r_valid[i] <= 1'b0;
               r_cmt[i]   <= 1'b0;
            end
         end
         if (w_pop0) begin
            r_valid[w_head_idx] <= 1'b0;
            r_cmt[w_head_idx]   <= 1'b0;
         end
         if (w_pop1) begin
            r_valid[w_head1_idx] <= 1'b0;
            r_cmt[w_head1_idx]   <= 1'b0;
         end
         if (w_enq) begin
            r_valid[w_wr_idx] <= 1'b1;
            r_cmt[w_wr_idx]   <= 1'b0;
         end
      end
   end

   // Entry payload capture at the (possibly retracted) tail
   always_ff @(posedge clk) begin
      if (w_enq) begin
         r_sqn[w_wr_idx]  <= sq.in_st_sqn;
         r_addr[w_wr_idx] <= sq.in_st_addr;
         r_data[w_wr_idx] <= sq.in_st_data;
         r_mask[w_wr_idx] <= sq.in_st_wmask;
      end
   end

   // Pointers and registered occupancy status
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
      end else begin
         r_head  <= w_head_nxt;
         r_tail  <= w_tail_nxt;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0) && !w_out_valid_nxt;
      end
   end

   // Cache write register, held while stalled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_valid <= 1'b0;
         r_out_addr  <= '0;
         r_out_data  <= '0;
         r_out_mask  <= '0;
      end else begin
         r_out_valid <= w_out_valid_nxt;
         if (w_pop0) begin
            r_out_addr <= r_addr[w_head_idx];
            r_out_data <= w_mrg_data;
            r_out_mask <= w_mrg_mask;
         end
      end
   end

   // Forwarding result register, one cycle after the lookup
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_fwd_valid <= 1'b0;
         r_fwd_data  <= '0;
         r_fwd_mask  <= '0;
      end else begin
         r_fwd_valid <= sq.in_ld_valid;
         r_fwd_data  <= w_fwd_data;
         r_fwd_mask  <= w_fwd_mask;
      end
   end

   assign sq.in_st_ready   = !w_full;
   assign sq.out_st_valid  = r_out_valid;
   assign sq.out_st_addr   = r_out_addr;
   assign sq.out_st_data   = r_out_data;
   assign sq.out_st_wmask  = r_out_mask;
   assign sq.out_fwd_valid = r_fwd_valid;
   assign sq.out_fwd_data  = r_fwd_data;
   assign sq.out_fwd_mask  = r_fwd_mask;
   assign sq.out_empty     = r_empty;
   assign sq.out_count     = r_count;
endmodule
